// File: rtl/jfpjc_pkg.sv
// Shared constants, drain state encoding and helpers for the jfpjc DCT output path.
package jfpjc_pkg;

    localparam int DCT_BLOCK_WORDS = 64;
    localparam int COEF_W          = 16;
    localparam int NUM_DCTS        = 5;
    localparam int NUM_BUFS        = 4;

    typedef enum logic [1:0] {
        ARM,
        IDLE,
        READ
    } drain_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/jfpjc_skid_fifo2.sv
// Two-entry first-word-fall-through FIFO; the head entry is always presented on head_data.
module jfpjc_skid_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       count_q;

    // Entry 0 is the head; entry 1 only holds data while two words are queued.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (pop && count_q != 2'd0) begin
            if (push) begin
                if (count_q == 2'd1) begin
                    head_q <= push_data;
                end else begin
                    head_q <= tail_q;
                    tail_q <= push_data;
                end
            end else begin
                head_q  <= tail_q;
                count_q <= count_q - 2'd1;
            end
        end else if (push && count_q != 2'd2) begin
            if (count_q == 2'd0) begin
                head_q <= push_data;
            end else begin
                tail_q <= push_data;
            end
            count_q <= count_q + 2'd1;
        end
    end

    assign head_data = head_q;
    assign count     = count_q;

endmodule

// File: rtl/jfpjc_dct_drain.sv
// Drains the just-completed back buffer of every DCT output memory after each frontbuffer
// flip and streams the coefficients on a valid/ready interface.
module jfpjc_dct_drain #(
    parameter int  NUM_DCTS    = jfpjc_pkg::NUM_DCTS,
    parameter int  BLOCK_WORDS = jfpjc_pkg::DCT_BLOCK_WORDS,
    parameter int  NUM_BUFS    = jfpjc_pkg::NUM_BUFS,
    parameter int  COEF_W      = jfpjc_pkg::COEF_W,
    localparam int BUF_W       = jfpjc_pkg::clog2(NUM_BUFS),
    localparam int SEL_W       = jfpjc_pkg::clog2(NUM_DCTS),
    localparam int ADDR_W      = jfpjc_pkg::clog2(NUM_BUFS * BLOCK_WORDS)
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic [BUF_W-1:0]  dcts_frontbuffer,
    output logic              dct_rd_en,
    output logic [SEL_W-1:0]  dct_rd_sel,
    output logic [ADDR_W-1:0] dct_rd_addr,
    input  logic [COEF_W-1:0] dct_rd_data,
    output logic [COEF_W-1:0] coef_data,
    output logic              coef_valid,
    input  logic              coef_ready,
    output logic [SEL_W-1:0]  coef_dct_idx,
    output logic              coef_first,
    output logic              coef_last,
    output logic              busy,
    output logic              overrun,
    input  logic              overrun_clear
);

    import jfpjc_pkg::*;

    localparam int WORD_W = clog2(BLOCK_WORDS);
    localparam int FIFO_W = COEF_W + SEL_W + 2;

    drain_state_t      state;
    logic [BUF_W-1:0]  prev_fb;
    logic [BUF_W-1:0]  slot;
    logic [SEL_W-1:0]  dct;
    logic [WORD_W-1:0] word;
    logic              pend_valid;
    logic [BUF_W-1:0]  pend_slot;
    logic              rd_q;
    logic [SEL_W-1:0]  tag_dct_q;
    logic              tag_first_q;
    logic              tag_last_q;
    logic [FIFO_W-1:0] fifo_head;
    logic [1:0]        fifo_count;
    logic [2:0]        occupancy;
    logic              flip;
    logic              pop;
    logic              issue;
    logic              last_read;

    assign flip = (state != ARM) && (dcts_frontbuffer != prev_fb);
    assign pop  = coef_valid && coef_ready;

    // Counting this cycle's pop is what lets a 2-entry FIFO sustain one word per clock without loss.
    assign occupancy = 3'(fifo_count) - 3'(pop) + 3'(rd_q);
    assign issue     = (state == READ) && (occupancy < 3'd2);
    assign last_read = issue && (dct == SEL_W'(NUM_DCTS - 1)) && (word == WORD_W'(BLOCK_WORDS - 1));

    assign dct_rd_en   = issue;
    assign dct_rd_sel  = dct;
    assign dct_rd_addr = ADDR_W'(slot) * ADDR_W'(BLOCK_WORDS) + ADDR_W'(word);

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state       <= ARM;
            prev_fb     <= '0;
            slot        <= '0;
            dct         <= '0;
            word        <= '0;
            pend_valid  <= 1'b0;
            pend_slot   <= '0;
            overrun     <= 1'b0;
            rd_q        <= 1'b0;
            tag_dct_q   <= '0;
            tag_first_q <= 1'b0;
            tag_last_q  <= 1'b0;
        end else begin
            prev_fb     <= dcts_frontbuffer;
            rd_q        <= issue;
            tag_dct_q   <= dct;
            tag_first_q <= (word == '0);
            tag_last_q  <= last_read;
            if (overrun_clear) begin
                overrun <= 1'b0;
            end
            case (state)
                ARM: begin
                    state <= IDLE;
                end
                IDLE: begin
                    if (flip) begin
                        slot  <= prev_fb;
                        dct   <= '0;
                        word  <= '0;
                        state <= READ;
                    end
                end
                READ: begin
                    if (issue) begin
                        if (word == WORD_W'(BLOCK_WORDS - 1)) begin
                            word <= '0;
                            dct  <= dct + 1'b1;
                        end else begin
                            word <= word + 1'b1;
                        end
                    end
                    // A flip landing on the final read becomes the next group directly.
                    if (last_read) begin
                        dct  <= '0;
                        word <= '0;
                        if (pend_valid) begin
                            slot       <= pend_slot;
                            pend_valid <= flip;
                            pend_slot  <= prev_fb;
                        end else if (flip) begin
                            slot <= prev_fb;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (flip) begin
                        if (!pend_valid) begin
                            pend_valid <= 1'b1;
                            pend_slot  <= prev_fb;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ARM;
                end
            endcase
        end
    end

    jfpjc_skid_fifo2 #(
        .WIDTH(FIFO_W)
    ) u_fifo (
        .clock     (clock),
        .nreset    (nreset),
        .push      (rd_q),
        .push_data ({dct_rd_data, tag_dct_q, tag_first_q, tag_last_q}),
        .pop       (pop),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    assign {coef_data, coef_dct_idx, coef_first, coef_last} = fifo_head;
    assign coef_valid = (fifo_count != 2'd0);
    assign busy       = (state == READ) || pend_valid || rd_q || (fifo_count != 2'd0);

endmodule

// File: tb/tb_jfpjc_dct_drain.sv
// Randomized bench for jfpjc_dct_drain: memory model plus a slot-list reference stream.
module tb_jfpjc_dct_drain;

    localparam int GROUP = 320;

    logic        clock = 1'b0;
    logic        nreset = 1'b0;
    logic [1:0]  dcts_frontbuffer = 2'd0;
    logic        dct_rd_en;
    logic [2:0]  dct_rd_sel;
    logic [7:0]  dct_rd_addr;
    logic [15:0] dct_rd_data = 16'd0;
    logic [15:0] coef_data;
    logic        coef_valid;
    logic        coef_ready = 1'b0;
    logic [2:0]  coef_dct_idx;
    logic        coef_first;
    logic        coef_last;
    logic        busy;
    logic        overrun;
    logic        overrun_clear = 1'b0;

    jfpjc_dct_drain dut (
        .clock            (clock),
        .nreset           (nreset),
        .dcts_frontbuffer (dcts_frontbuffer),
        .dct_rd_en        (dct_rd_en),
        .dct_rd_sel       (dct_rd_sel),
        .dct_rd_addr      (dct_rd_addr),
        .dct_rd_data      (dct_rd_data),
        .coef_data        (coef_data),
        .coef_valid       (coef_valid),
        .coef_ready       (coef_ready),
        .coef_dct_idx     (coef_dct_idx),
        .coef_first       (coef_first),
        .coef_last        (coef_last),
        .busy             (busy),
        .overrun          (overrun),
        .overrun_clear    (overrun_clear)
    );

    always #5 clock = ~clock;

    int          total = 0;
    int          bad = 0;
    int          coef_n = 0;
    int          rd_n = 0;
    int          issued = 0;
    int          hs = 0;
    int          max_out = 0;
    int          gaps = 0;
    bit          gap_en = 1'b0;
    bit          stalled_prev = 1'b0;
    logic [20:0] prev_coef = '0;
    logic [20:0] mon_cur;
    bit          mon_hsk;
    int          ready_pct = 100;
    int          slots_q[$];
    logic [15:0] mem [0:4][0:255];

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference stream: every accepted group is slot s, DCT 0..4, words 0..63.
    function automatic logic [10:0] expRead(input int n);
        int g;
        int r;
        g = n / GROUP;
        if (g >= slots_q.size()) return '1;
        r = n % GROUP;
        return {3'(r / 64), 8'(slots_q[g] * 64 + r % 64)};
    endfunction

    function automatic logic [20:0] expCoef(input int n);
        int g;
        int r;
        int d;
        int w;
        g = n / GROUP;
        if (g >= slots_q.size()) return '1;
        r = n % GROUP;
        d = r / 64;
        w = r % 64;
        return {16'(slots_q[g] * 512 + d * 64 + w), 3'(d), (w == 0), (d == 4 && w == 63)};
    endfunction

    initial begin
        for (int d = 0; d < 5; d++) begin
            for (int a = 0; a < 256; a++) begin
                mem[d][a] = 16'((a / 64) * 512 + d * 64 + (a % 64));
            end
        end
    end

    // DCT output memories with one cycle of read latency.
    always @(posedge clock) begin
        if (dct_rd_en && dct_rd_sel < 3'd5) dct_rd_data <= mem[dct_rd_sel][dct_rd_addr];
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            coef_ready = (ready_pct >= 100) || ($urandom_range(0, 99) < ready_pct);
        end
    end

    always @(negedge clock) begin
        if (nreset) begin
            mon_cur = {coef_data, coef_dct_idx, coef_first, coef_last};
            mon_hsk = coef_valid && coef_ready;
            if (issued - hs > max_out) max_out = issued - hs;
            if (dct_rd_en) begin
                checkOutput("rd_req", 64'({dct_rd_sel, dct_rd_addr}), 64'(expRead(rd_n)));
                rd_n++;
            end
            if (stalled_prev) checkOutput("hold", 64'({coef_valid, mon_cur}), 64'({1'b1, prev_coef}));
            if (mon_hsk) begin
                checkOutput("coef", 64'(mon_cur), 64'(expCoef(coef_n)));
                coef_n++;
            end
            if (gap_en && !coef_valid) gaps++;
            stalled_prev = coef_valid && !coef_ready;
            prev_coef = mon_cur;
            issued += int'(dct_rd_en);
            hs += int'(mon_hsk);
        end
    end

    task automatic clearModel();
        coef_n = 0;
        rd_n = 0;
        issued = 0;
        hs = 0;
        max_out = 0;
        gaps = 0;
        gap_en = 1'b0;
        stalled_prev = 1'b0;
    endtask

    task automatic applyStimulus(input logic [1:0] fb);
        @(posedge clock);
        #1;
        dcts_frontbuffer = fb;
    endtask

    task automatic applyReset(input logic [1:0] fb);
        @(posedge clock);
        #1;
        nreset = 1'b0;
        dcts_frontbuffer = fb;
        overrun_clear = 1'b0;
        #1;
        checkOutput("reset_out", 64'({coef_valid, coef_data, coef_dct_idx, coef_first, coef_last,
                    dct_rd_en, dct_rd_sel, dct_rd_addr, busy, overrun}), 64'd0);
        repeat (3) @(posedge clock);
        #1;
        clearModel();
        nreset = 1'b1;
        repeat (2) @(posedge clock);
    endtask

    task automatic waitCoefs(input int n, input int budget, input string tag);
        int c;
        c = 0;
        while (coef_n < n && c < budget) begin
            @(posedge clock);
            c++;
        end
        checkOutput(tag, 64'(coef_n), 64'(n));
    endtask

    task automatic idleCheck(input string tag, input int n);
        repeat (30) @(posedge clock);
        checkOutput({tag, "_count"}, 64'(coef_n), 64'(n));
        checkOutput({tag, "_reads"}, 64'(rd_n), 64'(n));
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] rdv;
        logic [3:0] vv;
        bit         hit;

        // Single drain with the consumer always ready, including first-word latency.
        applyReset(2'd0);
        checkOutput("idle_busy", 64'(busy), 64'd0);
        slots_q = '{0};
        ready_pct = 100;
        applyStimulus(2'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            rdv[k] = dct_rd_en;
            vv[k] = coef_valid;
        end
        checkOutput("t1_rd_latency", 64'(rdv), 64'(4'b1110));
        checkOutput("t1_valid_latency", 64'(vv), 64'(4'b1000));
        waitCoefs(1, 50, "t1_first");
        gap_en = 1'b1;
        waitCoefs(GROUP, 2000, "t1_all");
        gap_en = 1'b0;
        checkOutput("t1_gaps", 64'(gaps), 64'd0);
        idleCheck("t1", GROUP);
        checkOutput("t1_overrun", 64'(overrun), 64'd0);

        // Random backpressure must not lose, duplicate or overfill.
        applyReset(2'd0);
        slots_q = '{0};
        ready_pct = 30;
        applyStimulus(2'd1);
        waitCoefs(GROUP, 6000, "t2_all");
        ready_pct = 100;
        idleCheck("t2", GROUP);
        checkOutput("t2_inflight", 64'(max_out <= 2), 64'd1);

        // Second flip during a drain is queued and follows with no gap.
        applyReset(2'd0);
        slots_q = '{0, 1};
        applyStimulus(2'd1);
        waitCoefs(1, 50, "t3_first");
        gap_en = 1'b1;
        waitCoefs(100, 500, "t3_hundred");
        applyStimulus(2'd2);
        waitCoefs(2 * GROUP, 3000, "t3_all");
        gap_en = 1'b0;
        checkOutput("t3_gaps", 64'(gaps), 64'd0);
        checkOutput("t3_overrun", 64'(overrun), 64'd0);
        idleCheck("t3", 2 * GROUP);

        // Third flip within one drain is dropped and flagged until cleared.
        applyReset(2'd0);
        slots_q = '{0, 1};
        ready_pct = 50;
        applyStimulus(2'd1);
        repeat (5) @(posedge clock);
        applyStimulus(2'd2);
        repeat (5) @(posedge clock);
        checkOutput("t4_overrun_early", 64'(overrun), 64'd0);
        applyStimulus(2'd3);
        waitCoefs(2 * GROUP, 8000, "t4_all");
        ready_pct = 100;
        idleCheck("t4", 2 * GROUP);
        checkOutput("t4_overrun_set", 64'(overrun), 64'd1);
        repeat (10) @(posedge clock);
        checkOutput("t4_overrun_sticky", 64'(overrun), 64'd1);
        @(posedge clock);
        #1;
        overrun_clear = 1'b1;
        @(posedge clock);
        #1;
        overrun_clear = 1'b0;
        checkOutput("t4_overrun_clear", 64'(overrun), 64'd0);

        // Reset in the middle of a drain, frontbuffer nonzero through release.
        applyReset(2'd0);
        slots_q = '{0};
        applyStimulus(2'd1);
        waitCoefs(50, 500, "t5_fifty");
        #1;
        nreset = 1'b0;
        dcts_frontbuffer = 2'd2;
        #1;
        checkOutput("t5_reset_out", 64'({coef_valid, coef_data, coef_dct_idx, coef_first, coef_last,
                    dct_rd_en, dct_rd_sel, dct_rd_addr, busy, overrun}), 64'd0);
        repeat (3) @(posedge clock);
        #1;
        clearModel();
        nreset = 1'b1;
        repeat (20) @(posedge clock);
        checkOutput("t5_no_drain_reads", 64'(rd_n), 64'd0);
        checkOutput("t5_no_drain_busy", 64'(busy), 64'd0);
        slots_q = '{2};
        applyStimulus(2'd3);
        waitCoefs(GROUP, 2000, "t5_all");
        idleCheck("t5", GROUP);

        // Flip on exactly the cycle of the final read of a group.
        applyReset(2'd0);
        slots_q = '{0, 1};
        applyStimulus(2'd1);
        waitCoefs(1, 50, "t6_first");
        gap_en = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 1000 && !hit; c++) begin
            @(posedge clock);
            #1;
            if (dct_rd_en && dct_rd_sel == 3'd4 && dct_rd_addr[5:0] == 6'd63) begin
                dcts_frontbuffer = 2'd2;
                hit = 1'b1;
            end
        end
        checkOutput("t6_last_read_seen", 64'(hit), 64'd1);
        waitCoefs(2 * GROUP, 3000, "t6_all");
        gap_en = 1'b0;
        checkOutput("t6_gaps", 64'(gaps), 64'd0);
        checkOutput("t6_overrun", 64'(overrun), 64'd0);
        idleCheck("t6", 2 * GROUP);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
